instr_issue_ctrl: RTL and testbench
===================================

Name: instr_issue_ctrl

Overview:
- Sequencer in front of instruction_decode.
- Reads 64-bit instructions from the on-chip instruction memory starting at a programmed base address.
- Presents each instruction to the decoder with a one-cycle instr_enable pulse.
- Stalls until the datapath unit targeted by the opcode reports completion, then advances the program counter.
- Stops on the end-of-program opcode (0x82), holds on the verification opcode (0x44), and flags a stuck unit via a watchdog.

Parameters:
- ADDR_W, 10, instruction memory address width; PC wraps modulo 2^ADDR_W.
- INSTR_W, 64, instruction width; opcode is bits [INSTR_W-1 -: 8].
- TIMEOUT_CYC, 65535, maximum cycles in a WAIT state before error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begin execution at base_addr (honoured only in IDLE or HALT)
- abort  in  1  return to IDLE next cycle from any state
- base_addr  in  ADDR_W  first instruction address, sampled with start
- resume  in  1  release a 0x44 hold
- instr_mem_rd_en  out  1  memory read strobe
- instr_mem_addr  out  ADDR_W  memory read address (= pc)
- instr_mem_data  in  INSTR_W  memory read data, valid exactly 1 cycle after rd_en
- instruction  out  INSTR_W  instruction word to decoder
- instr_enable  out  1  one-cycle issue strobe to decoder
- fetch_done  in  1  completion pulse from feature/weight/bias fetchers
- compute_done  in  1  completion pulse from conv/line-buffer engine
- pc  out  ADDR_W  address of the current instruction
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- prog_done  out  1  one-cycle pulse on entering HALT via opcode 0x82
- timeout_err  out  1  sticky; set on watchdog expiry, cleared by start or rst

Behaviour:
- Reset: all outputs 0, pc = 0, state IDLE, watchdog = 0.
- FSM states: IDLE, READ, LATCH, ISSUE, WAIT_FETCH, WAIT_COMP, HOLD, HALT.
- IDLE/HALT + start: pc <= base_addr; timeout_err <= 0; next state READ.
- READ: instr_mem_rd_en = 1, instr_mem_addr = pc; next state LATCH.
- LATCH: instruction <= instr_mem_data; next state ISSUE.
- ISSUE: instr_enable = 1 for exactly this cycle. Next state by opcode:
  - 0x01, 0x02, 0x04 -> WAIT_FETCH
  - 0x81 -> WAIT_COMP
  - 0x44 -> HOLD
  - 0x82 -> HALT, with prog_done pulsed the same cycle HALT is entered
  - 0x40 and any other opcode -> READ, pc <= pc+1
- WAIT_FETCH: on fetch_done, pc <= pc+1 and go to READ. WAIT_COMP: same, on compute_done.
- Done inputs are sampled only in their own WAIT state. The decoder's 2-stage register path guarantees no completion earlier than 2 cycles after instr_enable. A done pulse in any other state is ignored.
- HOLD: on resume, pc <= pc+1 and go to READ. HOLD is not watchdog-timed.
- Watchdog: clears on entry to WAIT_FETCH/WAIT_COMP and increments each cycle in those states. When it reaches TIMEOUT_CYC without a done, set timeout_err and go to HALT; prog_done is not pulsed.
- Latency: start sampled at cycle 0 -> READ at 1, LATCH at 2, instr_enable at 3. A non-waiting instruction issues every 3 cycles. A waiting instruction issues 3 cycles after its done pulse.
- PC wrap: pc = 2^ADDR_W-1 increments to 0 without error.
- abort: highest priority in every state. Next cycle: IDLE, instr_enable = 0, rd_en = 0; pc holds its value.
- Simultaneous start and abort: abort wins.
- start while busy: ignored.
- rst mid-operation: full reset next edge, with no trailing instr_enable.
- instruction holds the last issued word until the next LATCH.

Decomposition:
- Shared package isa_pkg holds:
  - opcode constants: OP_CFG 8'h01, OP_FETCH 8'h02, OP_FETCH_W 8'h04, OP_CONV 8'h81, OP_VREG 8'h40, OP_END 8'h82, OP_HOLD 8'h44
  - the FSM state enum
  - the opcode-class enum (WAIT_F, WAIT_C, HOLD, END, NONE)
- One combinational sub-module, opcode_classifier (opcode -> class), reusable by the decoder and trace monitors.
- The watchdog counter stays inline.

Test Plan:
- Program [0x40.., 0x82..] at base 0x010, start at cycle 0 -> instr_enable at cycles 3 and 6. After the second issue: halted = 1, prog_done pulse, pc = 0x011. The 0x40 instruction is not waited on.
- Program [0x02.., 0x82..], fetch_done at 10 cycles after the first issue -> second instr_enable exactly 3 cycles after fetch_done. A fetch_done injected during READ is ignored and does not advance pc.
- 0x81 with compute_done withheld, TIMEOUT_CYC = 20 -> HALT after 20 wait cycles; timeout_err = 1; prog_done = 0. A new start clears timeout_err.
- 0x44 then 0x82, resume asserted 50 cycles later -> busy stays 1 and pc is stable during the hold; 0x82 issues 3 cycles after resume.
- abort asserted in WAIT_FETCH and again in LATCH -> IDLE next cycle, no instr_enable issued, pc unchanged. start and abort in the same cycle -> remains IDLE.
- base_addr = 0x3FF (ADDR_W = 10), non-waiting instruction there -> next read address is 0x000.

Source files
------------

// File: rtl/isa_pkg.sv
// isa_pkg
//   Shared definitions for the instruction issue path: opcode constants,
//   the issue sequencer state encoding and the opcode classes used to pick
//   which completion (if any) the sequencer waits for.
//   No ports.

package isa_pkg;

  localparam logic [7:0] OP_CFG     = 8'h01;
  localparam logic [7:0] OP_FETCH   = 8'h02;
  localparam logic [7:0] OP_FETCH_W = 8'h04;
  localparam logic [7:0] OP_CONV    = 8'h81;
  localparam logic [7:0] OP_VREG    = 8'h40;
  localparam logic [7:0] OP_END     = 8'h82;
  localparam logic [7:0] OP_HOLD    = 8'h44;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_READ       = 3'd1,
    S_LATCH      = 3'd2,
    S_ISSUE      = 3'd3,
    S_WAIT_FETCH = 3'd4,
    S_WAIT_COMP  = 3'd5,
    S_HOLD       = 3'd6,
    S_HALT       = 3'd7
  } issue_state_e;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_WAIT_F = 3'd1,
    CLS_WAIT_C = 3'd2,
    CLS_HOLD   = 3'd3,
    CLS_END    = 3'd4
  } op_class_e;

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier
//   Pure combinational map from an 8-bit opcode to its sequencing class.
//   Shared by the issue controller, the decoder and trace monitors so they
//   all agree on which opcodes wait on which unit.
// Ports:
//   opcode_i    in   8  opcode field of the instruction
//   op_class_o  out  3  sequencing class (op_class_e)

module opcode_classifier
  import isa_pkg::*;
(
  input  logic [7:0] opcode_i,
  output op_class_e  op_class_o
);

  always_comb begin
    op_class_o = CLS_NONE;
    case (opcode_i)
      OP_CFG, OP_FETCH, OP_FETCH_W: op_class_o = CLS_WAIT_F;
      OP_CONV:                      op_class_o = CLS_WAIT_C;
      OP_HOLD:                      op_class_o = CLS_HOLD;
      OP_END:                       op_class_o = CLS_END;
      default:                      op_class_o = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/instr_issue_ctrl.sv
// instr_issue_ctrl
//   Sequencer in front of the instruction decoder. Fetches instructions from
//   the instruction memory starting at base_addr, issues each one with a
//   single-cycle instr_enable, and stalls on the unit the opcode targets
//   before advancing the pc. Stops on END, holds on HOLD until resume, and
//   halts with a sticky timeout_err if a unit never reports completion.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | not running; waits for start
//   READ       | memory read strobe at address pc
//   LATCH      | memory data captured into the instruction register
//   ISSUE      | instr_enable high; next state chosen by opcode class
//   WAIT_FETCH | waiting on fetch_done (watchdog running)
//   WAIT_COMP  | waiting on compute_done (watchdog running)
//   HOLD       | waiting on resume (no watchdog)
//   HALT       | program ended or watchdog expired; start restarts
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, abort      begin at base_addr / return to IDLE (abort wins)
//   base_addr         first instruction address, sampled with start
//   resume            releases a HOLD
//   instr_mem_*       memory read port, data valid one cycle after rd_en
//   instruction       last latched instruction word
//   instr_enable      one-cycle issue strobe
//   fetch_done        completion pulse from the fetchers
//   compute_done      completion pulse from the conv engine
//   pc, busy, halted  status
//   prog_done         pulse on entering HALT through an END opcode
//   timeout_err       sticky watchdog flag, cleared by start or rst

module instr_issue_ctrl
  import isa_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int INSTR_W     = 64,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               resume,
  output logic               instr_mem_rd_en,
  output logic [ADDR_W-1:0]  instr_mem_addr,
  input  logic [INSTR_W-1:0] instr_mem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_enable,
  input  logic               fetch_done,
  input  logic               compute_done,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               prog_done,
  output logic               timeout_err
);

  // Watchdog only needs to count up to TIMEOUT_CYC-1.
  localparam int WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  issue_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               timeout_q, timeout_d;
  logic               prog_done_q, prog_done_d;

  logic [7:0] opcode;
  op_class_e  op_class;
  logic       wd_expired;

  assign opcode = instr_q[INSTR_W-1 -: 8];

  opcode_classifier u_classifier (
    .opcode_i   (opcode),
    .op_class_o (op_class)
  );

  assign wd_expired = (wdog_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
    prog_done_d = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc_d      = base_addr;
            timeout_d = 1'b0;
            state_d   = S_READ;
          end
        end
        S_READ:  state_d = S_LATCH;
        S_LATCH: begin
          instr_d = instr_mem_data;
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          // Watchdog is cleared here so it starts at zero on WAIT entry.
          wdog_d = '0;
          case (op_class)
            CLS_WAIT_F: state_d = S_WAIT_FETCH;
            CLS_WAIT_C: state_d = S_WAIT_COMP;
            CLS_HOLD:   state_d = S_HOLD;
            CLS_END: begin
              state_d     = S_HALT;
              prog_done_d = 1'b1;
            end
            default: begin
              pc_d    = pc_q + ADDR_W'(1);
              state_d = S_READ;
            end
          endcase
        end
        S_WAIT_FETCH, S_WAIT_COMP: begin
          if ((state_q == S_WAIT_FETCH) ? fetch_done : compute_done) begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_READ;
          end else if (wd_expired) begin
            timeout_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
        S_HOLD: begin
          if (resume) begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
      prog_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
      prog_done_q <= prog_done_d;
    end
  end

  assign instr_mem_rd_en = (state_q == S_READ);
  assign instr_mem_addr  = pc_q;
  assign instruction     = instr_q;
  assign instr_enable    = (state_q == S_ISSUE);
  assign pc              = pc_q;
  assign busy            = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted          = (state_q == S_HALT);
  assign prog_done       = prog_done_q;
  assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
module tb_instr_issue_ctrl;

  localparam int AW = 10;
  localparam int IW = 64;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          resume = 1'b0;
  logic          fetch_done = 1'b0;
  logic          compute_done = 1'b0;
  logic [AW-1:0] base_addr = '0;

  logic          rd_en;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_data;
  logic [IW-1:0] instruction;
  logic          instr_enable;
  logic [AW-1:0] pc;
  logic          busy, halted, prog_done, timeout_err;

  instr_issue_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .TIMEOUT_CYC(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .base_addr       (base_addr),
    .resume          (resume),
    .instr_mem_rd_en (rd_en),
    .instr_mem_addr  (mem_addr),
    .instr_mem_data  (mem_data),
    .instruction     (instruction),
    .instr_enable    (instr_enable),
    .fetch_done      (fetch_done),
    .compute_done    (compute_done),
    .pc              (pc),
    .busy            (busy),
    .halted          (halted),
    .prog_done       (prog_done),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (rd_en) mem_data <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [IW-1:0] w;
  } issue_t;

  issue_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always @(negedge clk) begin
    issue_t e;
    if (!rst && instr_enable) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_issue: got issue at cycle %0d pc %h word %h, required no issue",
                 cyc, pc, instruction);
      end else begin
        e = exp_q.pop_front();
        if (e.c != cyc || e.a != pc || e.w != instruction) begin
          miscompares++;
          $display("FAIL issue: got cycle %0d pc %h word %h, required cycle %0d pc %h word %h",
                   cyc, pc, instruction, e.c, e.a, e.w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_issue(input int c, input logic [AW-1:0] a);
    issue_t e;
    e.c = c;
    e.a = a;
    e.w = mem[a];
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1);
  end

  int c0;
  int c1;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[10'h010] = {8'h40, 56'h00_0000_0000_1010};
    mem[10'h011] = {8'h82, 56'h00_0000_0000_1011};
    mem[10'h020] = {8'h02, 56'h00_0000_0000_2020};
    mem[10'h021] = {8'h82, 56'h00_0000_0000_2021};
    mem[10'h030] = {8'h81, 56'h00_0000_0000_3030};
    mem[10'h040] = {8'h44, 56'h00_0000_0000_4040};
    mem[10'h041] = {8'h82, 56'h00_0000_0000_4041};
    mem[10'h050] = {8'h02, 56'h00_0000_0000_5050};
    mem[10'h3FF] = {8'h40, 56'h00_0000_0000_3FF0};
    mem[10'h000] = {8'h82, 56'h00_0000_0000_0000};

    // reset values
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_prog_done", prog_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr_enable", instr_enable, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_instruction", instruction, 0);
    rst = 1'b0;
    tick();

    // non-waiting 0x40 then END
    c0 = cyc;
    base_addr = 10'h010;
    start = 1'b1;
    push_issue(c0 + 3, 10'h010);
    push_issue(c0 + 6, 10'h011);
    tick();
    start = 1'b0;
    wait_to(c0 + 7);
    chk("t1_halted", halted, 1);
    chk("t1_prog_done", prog_done, 1);
    chk("t1_pc", pc, 10'h011);
    tick();
    chk("t1_prog_done_pulse", prog_done, 0);
    chk("t1_halted_hold", halted, 1);

    // fetch wait; stray fetch_done during READ is ignored
    wait_to(c0 + 12);
    c0 = cyc;
    base_addr = 10'h020;
    start = 1'b1;
    push_issue(c0 + 3, 10'h020);
    tick();
    start = 1'b0;
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    wait_to(c0 + 12);
    chk("t2_waiting_busy", busy, 1);
    chk("t2_waiting_pc", pc, 10'h020);
    wait_to(c0 + 13);
    fetch_done = 1'b1;
    push_issue(c0 + 16, 10'h021);
    tick();
    fetch_done = 1'b0;
    wait_to(c0 + 17);
    chk("t2_halted", halted, 1);
    chk("t2_prog_done", prog_done, 1);
    chk("t2_pc", pc, 10'h021);

    // compute wait with no completion -> watchdog
    wait_to(c0 + 20);
    c0 = cyc;
    base_addr = 10'h030;
    start = 1'b1;
    push_issue(c0 + 3, 10'h030);
    tick();
    start = 1'b0;
    wait_to(c0 + 23);
    chk("t3_still_waiting", busy, 1);
    chk("t3_not_halted", halted, 0);
    tick();
    chk("t3_halted", halted, 1);
    chk("t3_timeout_err", timeout_err, 1);
    chk("t3_no_prog_done", prog_done, 0);
    chk("t3_pc", pc, 10'h030);
    wait_to(c0 + 26);
    c1 = cyc;
    base_addr = 10'h010;
    start = 1'b1;
    push_issue(c1 + 3, 10'h010);
    push_issue(c1 + 6, 10'h011);
    tick();
    start = 1'b0;
    chk("t3_timeout_cleared", timeout_err, 0);
    wait_to(c1 + 8);

    // HOLD then END, resume 50 cycles later
    c0 = cyc;
    base_addr = 10'h040;
    start = 1'b1;
    push_issue(c0 + 3, 10'h040);
    tick();
    start = 1'b0;
    wait_to(c0 + 10);
    fetch_done = 1'b1;
    compute_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    compute_done = 1'b0;
    wait_to(c0 + 30);
    chk("t4_hold_busy", busy, 1);
    chk("t4_hold_pc", pc, 10'h040);
    chk("t4_hold_no_timeout", timeout_err, 0);
    wait_to(c0 + 52);
    chk("t4_hold_pc_late", pc, 10'h040);
    chk("t4_hold_not_halted", halted, 0);
    wait_to(c0 + 53);
    resume = 1'b1;
    push_issue(c0 + 56, 10'h041);
    tick();
    resume = 1'b0;
    wait_to(c0 + 57);
    chk("t4_halted", halted, 1);
    chk("t4_prog_done", prog_done, 1);

    // abort in WAIT_FETCH, in LATCH, and together with start
    wait_to(c0 + 60);
    c0 = cyc;
    base_addr = 10'h050;
    start = 1'b1;
    push_issue(c0 + 3, 10'h050);
    tick();
    start = 1'b0;
    wait_to(c0 + 8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_wait_busy", busy, 0);
    chk("t5_abort_wait_halted", halted, 0);
    chk("t5_abort_wait_pc", pc, 10'h050);
    chk("t5_abort_wait_rd_en", rd_en, 0);
    wait_to(c0 + 12);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_latch_busy", busy, 0);
    chk("t5_abort_latch_pc", pc, 10'h050);
    chk("t5_abort_latch_instr", instruction, mem[10'h050]);
    wait_to(c0 + 18);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t5_start_abort_busy", busy, 0);
    chk("t5_start_abort_rd_en", rd_en, 0);
    wait_to(c0 + 24);

    // pc wrap at top of memory
    c0 = cyc;
    base_addr = 10'h3FF;
    start = 1'b1;
    push_issue(c0 + 3, 10'h3FF);
    push_issue(c0 + 6, 10'h000);
    tick();
    start = 1'b0;
    wait_to(c0 + 4);
    chk("t6_wrap_rd_en", rd_en, 1);
    chk("t6_wrap_addr", mem_addr, 10'h000);
    wait_to(c0 + 7);
    chk("t6_halted", halted, 1);
    chk("t6_pc", pc, 10'h000);
    chk("t6_no_timeout", timeout_err, 0);

    // reset during LATCH: no trailing issue
    wait_to(c0 + 10);
    c0 = cyc;
    base_addr = 10'h010;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_pc", pc, 0);
    chk("t7_rst_instr_enable", instr_enable, 0);
    chk("t7_rst_instruction", instruction, 0);
    wait_to(c0 + 8);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
